// File: rtl/apb_intercon_s_pkg.sv
// Shared types and constants for the apb_intercon_s shared-bus APB interconnect.
// Consumed by apb_intercon_s and apb_rr_arbiter.
package apb_intercon_s_pkg;

    localparam int DEF_MASTER_PORTS = 4;
    localparam int DEF_SLAVE_PORTS  = 4;
    localparam int DEF_BUS_WIDTH    = 16;
    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_ADDR_MSB     = 7;
    localparam int DEF_ADDR_LSB     = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    function automatic int sel_width(input int msb, input int lsb);
        return msb - lsb + 1;
    endfunction

endpackage

// File: rtl/apb_intercon_s_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index from a request vector.
// The search pointer moves past the winner only when the grant is accepted.
module apb_rr_arbiter
    import apb_intercon_s_pkg::*;
#(
    parameter int PORTS = DEF_MASTER_PORTS,
    parameter int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] req,
    input  logic             accept,
    output logic [PORTS-1:0] grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr;
    logic             found;

    // Priority order is ptr, ptr+1, ... wrapping modulo PORTS.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            for (int unsigned j = 0; j < PORTS; j++) begin
                if (!found && req[j] && (j == (32'(ptr) + i) % PORTS)) begin
                    found     = 1'b1;
                    grant[j]  = 1'b1;
                    grant_idx = IDX_W'(j);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (grant_idx == IDX_W'(PORTS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/apb_intercon_s.sv
// Shared-bus APB interconnect: round-robin master grant, re-issued SETUP/ACCESS to the decoded slave.
// Define APB_INTERCON_FORMAL_EN to compile in the embedded protocol assertions.
module apb_intercon_s
    import apb_intercon_s_pkg::*;
#(
    parameter int MASTER_PORTS = DEF_MASTER_PORTS,
    parameter int SLAVE_PORTS  = DEF_SLAVE_PORTS,
    parameter int BUS_WIDTH    = DEF_BUS_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_MSB     = DEF_ADDR_MSB,
    parameter int ADDR_LSB     = DEF_ADDR_LSB
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [MASTER_PORTS*BUS_WIDTH-1:0]  S_PADDR,
    input  logic [MASTER_PORTS-1:0]            S_PWRITE,
    input  logic [MASTER_PORTS-1:0]            S_PSELx,
    input  logic [MASTER_PORTS-1:0]            S_PENABLE,
    input  logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PWDATA,
    output logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PRDATA,
    output logic [MASTER_PORTS-1:0]            S_PREADY,
    output logic [BUS_WIDTH-1:0]               M_PADDR,
    output logic                               M_PWRITE,
    output logic [SLAVE_PORTS-1:0]             M_PSELx,
    output logic                               M_PENABLE,
    output logic [DATA_WIDTH-1:0]              M_PWDATA,
    input  logic [SLAVE_PORTS*DATA_WIDTH-1:0]  M_PRDATA,
    input  logic [SLAVE_PORTS-1:0]             M_PREADY
);

    localparam int IDX_W = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1;
    localparam int SEL_W = sel_width(ADDR_MSB, ADDR_LSB);

    apb_state_e                state, state_next;
    logic [MASTER_PORTS-1:0]   grant;
    logic [IDX_W-1:0]          grant_idx, grant_q;
    logic [BUS_WIDTH-1:0]      paddr_q, paddr_mux;
    logic                      pwrite_q, pwrite_mux;
    logic [DATA_WIDTH-1:0]     pwdata_q, pwdata_mux;
    logic [SEL_W-1:0]          sel;
    logic [SLAVE_PORTS-1:0]    sel_onehot;
    logic                      slave_ready;
    logic [DATA_WIDTH-1:0]     slave_rdata;
    logic                      accept;
    logic                      penable_unused;

    assign penable_unused = ^S_PENABLE;
    assign accept         = (state == IDLE) && (|S_PSELx);
    assign sel            = paddr_q[ADDR_MSB:ADDR_LSB];

    assign M_PADDR  = paddr_q;
    assign M_PWRITE = pwrite_q;
    assign M_PWDATA = pwdata_q;

    apb_rr_arbiter #(
        .PORTS (MASTER_PORTS),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk       (clk),
        .rst       (reset),
        .req       (S_PSELx),
        .accept    (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        paddr_mux  = '0;
        pwrite_mux = 1'b0;
        pwdata_mux = '0;
        for (int unsigned m = 0; m < MASTER_PORTS; m++) begin
            if (grant[m]) begin
                paddr_mux  = S_PADDR[m*BUS_WIDTH +: BUS_WIDTH];
                pwrite_mux = S_PWRITE[m];
                pwdata_mux = S_PWDATA[m*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant_q  <= '0;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                grant_q  <= grant_idx;
                paddr_q  <= paddr_mux;
                pwrite_q <= pwrite_mux;
                pwdata_q <= pwdata_mux;
            end
        end
    end

    // An undecoded slave select leaves slave_ready high so the transfer self-completes with zero data.
    always_comb begin
        state_next  = state;
        M_PSELx     = '0;
        M_PENABLE   = 1'b0;
        S_PREADY    = '0;
        S_PRDATA    = '0;
        sel_onehot  = '0;
        slave_ready = 1'b1;
        slave_rdata = '0;
        for (int unsigned s = 0; s < SLAVE_PORTS; s++) begin
            if (sel == SEL_W'(s)) begin
                sel_onehot[s] = 1'b1;
                slave_ready   = M_PREADY[s];
                slave_rdata   = M_PRDATA[s*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        case (state)
            IDLE: begin
                if (accept) state_next = SETUP;
            end
            SETUP: begin
                M_PSELx    = sel_onehot;
                state_next = ACCESS;
            end
            ACCESS: begin
                M_PSELx   = sel_onehot;
                M_PENABLE = 1'b1;
                if (slave_ready) begin
                    state_next = IDLE;
                    for (int unsigned m = 0; m < MASTER_PORTS; m++) begin
                        if (grant_q == IDX_W'(m)) begin
                            S_PREADY[m]                          = 1'b1;
                            S_PRDATA[m*DATA_WIDTH +: DATA_WIDTH] = slave_rdata;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef APB_INTERCON_FORMAL_EN
    a_psel_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(M_PSELx));
    a_penable_access: assert property (@(posedge clk) disable iff (reset) M_PENABLE |-> (state == ACCESS));
    a_hold_stable: assert property (@(posedge clk) disable iff (reset)
        (state != IDLE) |=> (state == IDLE) ||
        ($stable(grant_q) && $stable(paddr_q) && $stable(pwrite_q) && $stable(pwdata_q)));
    a_pready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(S_PREADY));
`else
    // default build carries no assertion logic
`endif

endmodule

// File: tb/tb_apb_intercon_s.sv
// Self-checking bench for apb_intercon_s: vector table with per-cycle checks, scoreboard of completions,
// plus hand-written reset-abort and round-robin sequences.
`timescale 1ns/1ps
module tb_apb_intercon_s;

    localparam int MP = 4;
    localparam int SP = 4;
    localparam int BW = 16;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [MP*BW-1:0]  S_PADDR;
    logic [MP-1:0]     S_PWRITE;
    logic [MP-1:0]     S_PSELx;
    logic [MP-1:0]     S_PENABLE;
    logic [MP*DW-1:0]  S_PWDATA;
    logic [MP*DW-1:0]  S_PRDATA;
    logic [MP-1:0]     S_PREADY;
    logic [BW-1:0]     M_PADDR;
    logic              M_PWRITE;
    logic [SP-1:0]     M_PSELx;
    logic              M_PENABLE;
    logic [DW-1:0]     M_PWDATA;
    logic [SP*DW-1:0]  M_PRDATA;
    logic [SP-1:0]     M_PREADY;

    apb_intercon_s #(
        .MASTER_PORTS (MP),
        .SLAVE_PORTS  (SP),
        .BUS_WIDTH    (BW),
        .DATA_WIDTH   (DW),
        .ADDR_MSB     (7),
        .ADDR_LSB     (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .S_PADDR   (S_PADDR),
        .S_PWRITE  (S_PWRITE),
        .S_PSELx   (S_PSELx),
        .S_PENABLE (S_PENABLE),
        .S_PWDATA  (S_PWDATA),
        .S_PRDATA  (S_PRDATA),
        .S_PREADY  (S_PREADY),
        .M_PADDR   (M_PADDR),
        .M_PWRITE  (M_PWRITE),
        .M_PSELx   (M_PSELx),
        .M_PENABLE (M_PENABLE),
        .M_PWDATA  (M_PWDATA),
        .M_PRDATA  (M_PRDATA),
        .M_PREADY  (M_PREADY)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int unsigned m;
        int unsigned dat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int unsigned m;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [15:0] rd;
        int unsigned waits;
        logic [3:0]  exp_psel;
        logic [15:0] exp_rdata;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Scoreboard: every completion seen on S_PREADY must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (|S_PREADY)) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: got S_PREADY %b, want 0000", S_PREADY);
            end else begin
                e = sb.pop_front();
                check("sb_pready", 64'(S_PREADY), 64'(4'(1) << e.m));
                check("sb_prdata", 64'(S_PRDATA), 64'(e.dat) << (e.m * DW));
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int unsigned sel;
        sel = 32'(v.addr[7:4]);
        @(posedge clk); #1;
        for (int unsigned s = 0; s < SP; s++)
            M_PRDATA[s*DW +: DW] = (s == sel) ? v.rd : ~v.rd;
        if (v.exp_psel == 4'b0000) begin
            M_PREADY = '0;
            M_PRDATA = '1;
        end else begin
            M_PREADY = '1;
            if (v.waits > 0) M_PREADY = M_PREADY & ~(4'(1) << sel);
        end
        S_PADDR[v.m*BW +: BW]  = v.addr;
        S_PWDATA[v.m*DW +: DW] = v.wd;
        S_PWRITE = v.wr ? (S_PWRITE | (4'(1) << v.m)) : (S_PWRITE & ~(4'(1) << v.m));
        S_PSELx  = S_PSELx | (4'(1) << v.m);
        sb.push_back('{v.m, 32'(v.exp_rdata)});
        @(posedge clk);
        @(negedge clk);
        check("setup_psel",    64'(M_PSELx),   64'(v.exp_psel));
        check("setup_penable", 64'(M_PENABLE), 64'(0));
        check("setup_paddr",   64'(M_PADDR),   64'(v.addr));
        check("setup_pwrite",  64'(M_PWRITE),  64'(v.wr));
        check("setup_pwdata",  64'(M_PWDATA),  64'(v.wd));
        check("setup_pready",  64'(S_PREADY),  64'(0));
        @(posedge clk); #1;
        for (int unsigned w = 0; w <= v.waits; w++) begin
            @(negedge clk);
            check("access_penable", 64'(M_PENABLE), 64'(1));
            check("access_psel",    64'(M_PSELx),   64'(v.exp_psel));
            check("access_paddr",   64'(M_PADDR),   64'(v.addr));
            check("access_pwdata",  64'(M_PWDATA),  64'(v.wd));
            check("access_pready",  64'(S_PREADY),
                  (w == v.waits) ? 64'(4'(1) << v.m) : 64'(0));
            if (w < v.waits) begin
                @(posedge clk); #1;
                if (w == v.waits - 1) M_PREADY = '1;
            end
        end
        @(posedge clk); #1;
        S_PSELx  = S_PSELx & ~(4'(1) << v.m);
        M_PREADY = '1;
        @(negedge clk);
        check("idle_psel",    64'(M_PSELx),   64'(0));
        check("idle_penable", 64'(M_PENABLE), 64'(0));
        check("idle_pready",  64'(S_PREADY),  64'(0));
    endtask

    task automatic reset_abort();
        @(posedge clk); #1;
        M_PREADY = 4'b1011;
        S_PADDR[2*BW +: BW] = 16'h0020;
        S_PWDATA[2*DW +: DW] = 16'h4321;
        S_PWRITE = '0;
        S_PSELx  = 4'b0100;
        @(posedge clk);
        @(posedge clk); #2;
        check("abort_pre_penable", 64'(M_PENABLE), 64'(1));
        check("abort_pre_psel",    64'(M_PSELx),   64'(4'b0100));
        reset = 1'b1;
        #1;
        check("abort_psel",    64'(M_PSELx),   64'(0));
        check("abort_penable", 64'(M_PENABLE), 64'(0));
        check("abort_pready",  64'(S_PREADY),  64'(0));
        check("abort_prdata",  64'(S_PRDATA),  64'(0));
        check("abort_paddr",   64'(M_PADDR),   64'(0));
        check("abort_pwdata",  64'(M_PWDATA),  64'(0));
        S_PSELx  = '0;
        M_PREADY = '1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic rr_test();
        int unsigned got;
        @(posedge clk); #1;
        M_PREADY = '1;
        for (int unsigned s = 0; s < SP; s++)
            M_PRDATA[s*DW +: DW] = 16'hA000 + 16'(s);
        S_PADDR[0*BW +: BW] = 16'h0030;
        S_PADDR[3*BW +: BW] = 16'h0000;
        S_PWRITE = '0;
        S_PSELx  = 4'b1001;
        sb.push_back('{0, 32'hA003});
        sb.push_back('{3, 32'hA000});
        sb.push_back('{0, 32'hA003});
        sb.push_back('{3, 32'hA000});
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            @(negedge clk);
            if (|S_PREADY) got++;
        end
        check("rr_completions", 64'(got), 64'(4));
        @(posedge clk); #1;
        S_PSELx = '0;
    endtask

    initial begin
        vec_t vecs[7];
        reset     = 1'b1;
        S_PADDR   = '0;
        S_PWRITE  = '0;
        S_PSELx   = '0;
        S_PENABLE = '0;
        S_PWDATA  = '0;
        M_PRDATA  = '0;
        M_PREADY  = '1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_psel",    64'(M_PSELx),   64'(0));
        check("rst_penable", 64'(M_PENABLE), 64'(0));
        check("rst_paddr",   64'(M_PADDR),   64'(0));
        check("rst_pwrite",  64'(M_PWRITE),  64'(0));
        check("rst_pwdata",  64'(M_PWDATA),  64'(0));
        check("rst_pready",  64'(S_PREADY),  64'(0));
        check("rst_prdata",  64'(S_PRDATA),  64'(0));

        //        m  wr    addr      wd        rd        waits exp_psel  exp_rdata
        vecs[0] = '{2, 1'b0, 16'h0025, 16'h0000, 16'hBEEF, 0, 4'b0100, 16'hBEEF};
        vecs[1] = '{1, 1'b1, 16'h0010, 16'h1234, 16'h5A5A, 2, 4'b0010, 16'h5A5A};
        vecs[2] = '{0, 1'b0, 16'h00F0, 16'h0000, 16'h7777, 0, 4'b0000, 16'h0000};
        vecs[3] = '{3, 1'b1, 16'h0039, 16'hCAFE, 16'h0F0F, 1, 4'b1000, 16'h0F0F};
        vecs[4] = '{0, 1'b0, 16'hFF05, 16'h0000, 16'h1357, 0, 4'b0001, 16'h1357};
        vecs[5] = '{2, 1'b0, 16'h0140, 16'h0000, 16'h2468, 0, 4'b0000, 16'h0000};
        vecs[6] = '{1, 1'b0, 16'h003F, 16'h9999, 16'hFFFF, 3, 4'b1000, 16'hFFFF};
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        reset_abort();
        rr_test();

        repeat (2) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
